// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the IF stage and imem.
// At most one request is outstanding; the response arrives one or more
// cycles after the request is accepted.
interface instruction_fetch_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage RISC-V pipeline: fetches from imem and fills the
// IF/ID register (pc, instruction, inst_valid) consumed by the decoder.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned redirect trap,
// adds the fetch_misalign port).
module instruction_fetch #(
    parameter int                   PC_WIDTH   = 32,
    parameter int                   INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = 32'h0000_0000,
    parameter logic [INST_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic                  is_stall,
    input  logic                  is_branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    instruction_fetch_if.master   imem,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [INST_WIDTH-1:0] instruction,
`ifdef IF_MISALIGN_TRAP_EN
    output logic                  fetch_misalign,
`endif
    output logic                  inst_valid
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUF} state_t;

    state_t                state, state_n;
    logic [PC_WIDTH-1:0]   fpc, fpc_n, fpc_inc, pc_n, target, addr_c;
    logic [INST_WIDTH-1:0] buf_q, buf_n, instr_n;
    logic                  valid_n, kill, kill_n, req_c, hold;

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign, misalign_n;
    assign target         = branch_target;
    assign fetch_misalign = misalign;
`else
    logic unused_target_lsbs;
    assign target             = {branch_target[PC_WIDTH-1:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];
`endif

    assign fpc_inc        = fpc + PC_WIDTH'(4);
    assign hold           = is_stall | ~cpu_en;
    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;

    // Next-state, request and IF/ID update logic
    always_comb begin
        state_n = state;
        fpc_n   = fpc;
        kill_n  = kill;
        buf_n   = buf_q;
        pc_n    = pc;
        instr_n = instruction;
        valid_n = inst_valid;
        req_c   = 1'b0;
        addr_c  = fpc;
        if (!hold) begin
            instr_n = NOP_INST;
            valid_n = 1'b0;
        end
        if (is_branch_taken) begin
            fpc_n   = target;
            instr_n = NOP_INST;
            valid_n = 1'b0;
            unique case (state)
                S_WAIT: begin
                    // A response still in flight must be dropped when it lands
                    if (imem.imem_rvalid) begin
                        state_n = S_IDLE;
                        kill_n  = 1'b0;
                    end else begin
                        kill_n = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else begin
            unique case (state)
                S_IDLE: begin
                    req_c = cpu_en;
                    if (cpu_en) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (kill) begin
                            kill_n  = 1'b0;
                            state_n = S_IDLE;
                        end else if (!hold) begin
                            // Back-to-back: issue the next fetch in the same cycle
                            pc_n    = fpc;
                            instr_n = imem.imem_rdata;
                            valid_n = 1'b1;
                            fpc_n   = fpc_inc;
                            req_c   = 1'b1;
                            addr_c  = fpc_inc;
                        end else begin
                            buf_n   = imem.imem_rdata;
                            state_n = S_BUF;
                        end
                    end
                end
                S_BUF: begin
                    if (!hold) begin
                        pc_n    = fpc;
                        instr_n = buf_q;
                        valid_n = 1'b1;
                        fpc_n   = fpc_inc;
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
`ifdef IF_MISALIGN_TRAP_EN
        misalign_n = misalign | (is_branch_taken & (|branch_target[1:0]));
        // Trapped: never issue, drain any outstanding response, emit bubbles
        if (misalign) begin
            req_c   = 1'b0;
            pc_n    = pc;
            instr_n = NOP_INST;
            valid_n = 1'b0;
            if (state == S_IDLE || state == S_BUF) state_n = S_IDLE;
            if (state == S_WAIT && imem.imem_rvalid) begin
                state_n = S_IDLE;
                kill_n  = 1'b0;
            end
        end
`endif
    end

    // State and IF/ID registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            fpc         <= RESET_PC;
            kill        <= 1'b0;
            buf_q       <= '0;
            pc          <= RESET_PC;
            instruction <= NOP_INST;
            inst_valid  <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            fpc         <= fpc_n;
            kill        <= kill_n;
            buf_q       <= buf_n;
            pc          <= pc_n;
            instruction <= instr_n;
            inst_valid  <= valid_n;
`ifdef IF_MISALIGN_TRAP_EN
            misalign    <= misalign_n;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/enable/redirect/reset traffic against an in-order
// program-stream reference model and a variable-latency memory model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, cpu_en, is_stall, is_branch_taken;
    logic [31:0] branch_target, pc, instruction;
    logic        inst_valid;
`ifdef IF_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    instruction_fetch_if #(.PC_WIDTH(32), .INST_WIDTH(32)) imem_bus ();

    instruction_fetch #(
        .PC_WIDTH   (32),
        .INST_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_en          (cpu_en),
        .is_stall        (is_stall),
        .is_branch_taken (is_branch_taken),
        .branch_target   (branch_target),
        .imem            (imem_bus.master),
        .pc              (pc),
        .instruction     (instruction),
`ifdef IF_MISALIGN_TRAP_EN
        .fetch_misalign  (fetch_misalign),
`endif
        .inst_valid      (inst_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents: the four-instruction test program, then an address hash
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0030_0193;
            32'h4:   return 32'h0641_A083;
            32'h8:   return 32'h0640_8113;
            32'hC:   return 32'h0020_8133;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory model state
    int unsigned lat_mode = 1;   // 0 = random latency 1..4
    bit          pend_v = 1'b0;
    int unsigned pend_cnt = 0;
    logic [31:0] pend_a = '0;

    // Reference model state
    logic [31:0] next_fetch = '0;  // address the next request must carry
    logic [31:0] exp_pc = '0;      // pc of the next instruction to be delivered
    int unsigned n_deliv = 0;

    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic step(input bit r, input bit en, input bit st, input bit br, input logic [31:0] tg);
        logic [31:0] prev_pc, prev_instr;
        logic        prev_valid;
        bit          rv;
        @(negedge clk);
        rst             = r;
        cpu_en          = en;
        is_stall        = st;
        is_branch_taken = br;
        branch_target   = tg;
        rv = pend_v && (pend_cnt == 0);
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rv ? mem_fn(pend_a) : $urandom;
        #1;
        obs_req  = imem_bus.imem_req;
        obs_addr = imem_bus.imem_addr;
        if (r && obs_req) begin
            check("req_addr", obs_addr, next_fetch);
            if (pend_v && !rv) check("one_outstanding", 0, 1);
        end
        prev_pc    = pc;
        prev_instr = instruction;
        prev_valid = inst_valid;
        @(posedge clk);
        #1;
        if (!r) begin
            pend_v = 1'b0;
        end else begin
            if (rv) pend_v = 1'b0;
            else if (pend_v) pend_cnt--;
            if (obs_req) begin
                pend_v   = 1'b1;
                pend_a   = obs_addr;
                pend_cnt = (lat_mode == 0) ? $urandom_range(0, 3) : lat_mode - 1;
            end
        end
        if (!r) begin
            check("rst_pc", pc, 32'h0);
            check("rst_instr", instruction, NOP);
            check("rst_valid", inst_valid, 0);
            next_fetch = '0;
            exp_pc     = '0;
        end else if (br) begin
            check("br_pc", pc, prev_pc);
            check("br_instr", instruction, NOP);
            check("br_valid", inst_valid, 0);
            next_fetch = {tg[31:2], 2'b00};
            exp_pc     = {tg[31:2], 2'b00};
        end else begin
            if (obs_req) next_fetch = next_fetch + 32'd4;
            if (st || !en) begin
                check("hold_pc", pc, prev_pc);
                check("hold_instr", instruction, prev_instr);
                check("hold_valid", inst_valid, prev_valid);
            end else if (inst_valid) begin
                check("deliver_pc", pc, exp_pc);
                check("deliver_instr", instruction, mem_fn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end else begin
                check("bubble_pc", pc, prev_pc);
                check("bubble_instr", instruction, NOP);
            end
        end
    endtask

    task automatic run();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] saved_pc;
        bit          found;

        rst = 1'b0; cpu_en = 1'b0; is_stall = 1'b0; is_branch_taken = 1'b0;
        branch_target = '0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = '0;

        // Streaming at 1-cycle latency
        lat_mode = 1;
        do_reset();
        run();
        check("first_req", obs_req, 1);
        check("first_addr", obs_addr, 32'h0);
        check("first_bubble", inst_valid, 0);
        for (int i = 0; i < 4; i++) begin
            run();
            check("stream_addr", obs_addr, 32'(4 * (i + 1)));
            check("stream_pc", pc, 32'(4 * i));
            check("stream_instr", instruction, mem_fn(32'(4 * i)));
            check("stream_valid", inst_valid, 1);
        end

        // Stall with the next response buffered
        do_reset();
        run(); run(); run();
        check("pre_stall_pc", pc, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            check("stall_pc", pc, 32'h4);
            check("stall_instr", instruction, 32'h0641_A083);
        end
        run();
        check("release_pc", pc, 32'h8);
        check("release_valid", inst_valid, 1);
        run();
        check("after_buf_req", obs_req, 1);
        check("after_buf_addr", obs_addr, 32'hC);

        // Redirect with a 3-cycle request to 0xC in flight
        lat_mode = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            run();
            if (obs_req && obs_addr == 32'hC) found = 1'b1;
        end
        check("reach_0xC", found, 1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            run();
            if (obs_req) found = 1'b1;
        end
        check("redirect_req", found, 1);
        check("redirect_addr", obs_addr, 32'h100);

        // 4-cycle latency: three bubbles between instructions
        lat_mode = 4;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run();
            if (inst_valid) found = 1'b1;
        end
        check("lat4_first", found, 1);
        saved_pc = pc;
        for (int i = 0; i < 3; i++) begin
            run();
            check("lat4_bubble_valid", inst_valid, 0);
            check("lat4_bubble_pc", pc, saved_pc);
        end
        run();
        check("lat4_next_valid", inst_valid, 1);
        check("lat4_next_pc", pc, saved_pc + 32'd4);

        // Reset while a request is outstanding
        run();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        run();
        check("post_rst_req", obs_req, 1);
        check("post_rst_addr", obs_addr, 32'h0);

        // Misaligned redirect target
        lat_mode = 1;
        do_reset();
        run(); run(); run();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h102);
`ifdef IF_MISALIGN_TRAP_EN
        check("misalign_flag", fetch_misalign, 1);
        for (int i = 0; i < 5; i++) begin
            run();
            check("misalign_no_req", obs_req, 0);
            check("misalign_valid", inst_valid, 0);
        end
`else
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            run();
            if (obs_req) found = 1'b1;
        end
        check("misalign_req", found, 1);
        check("misalign_addr", obs_addr, 32'h100);
`endif

        // Fetch address wraps past the top of the address space
        do_reset();
        run();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            run();
            if (inst_valid) found = 1'b1;
        end
        check("wrap_top_seen", found, 1);
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        run();
        check("wrap_zero_pc", pc, 32'h0);
        check("wrap_zero_valid", inst_valid, 1);

        // Randomized traffic
        lat_mode = 0;
        do_reset();
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tg;
            tg = $urandom;
`ifdef IF_MISALIGN_TRAP_EN
            tg[1:0] = 2'b00;
`endif
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, tg);
        end
        check("random_progress", n_deliv > 50, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
